fetch_cycle: RTL and testbench
==============================

# fetch_cycle

Instruction-fetch stage of the 5-stage RV32 pipeline. It is the producer end of the IF/ID interface that the decode stage consumes. The block owns the fetch PC and drives a request/grant/response instruction-memory port with at most one outstanding request. It absorbs execute-stage redirects, hazard-unit stalls and flushes, and registers `InstrD`, `PCD` and `PCPlus4D` for decode, inserting NOP bubbles whenever no valid instruction is available.

## Interface
- `RESET_PC`, 32'h00000000: fetch address after reset.
- `NOP_INSTR`, 32'h00000013: bubble encoding (`addi x0,x0,0`).

Ports (one clock; reset is asynchronous and active-low):
- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  async active-low reset.
- `StallF`  in  1  hazard unit: issue no new memory request.
- `StallD`  in  1  hazard unit: hold the IF/ID register.
- `FlushD`  in  1  hazard unit: load a bubble into IF/ID.
- `PCSrcE`  in  1  execute: redirect taken.
- `PCTargetE`  in  32  redirect target.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  fetch byte address.
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  response valid; at least 1 cycle after `gnt`.
- `imem_rdata`  in  32  instruction word.
- `InstrD`, `PCD`, `PCPlus4D`  out  32  IF/ID register contents.
- `ValidD`  out  1  IF/ID holds a real instruction.
- `FetchBusy`  out  1  no instruction deliverable this cycle.

## Operation
- **Reset values:**
  - `InstrD`=`NOP_INSTR`, `PCD`=0, `PCPlus4D`=0, `ValidD`=0.
  - `pc_q`=`RESET_PC`, `kill`=0, state=REQ.
  - `imem_req` is 0 while `reset_n` is low.
- **`pc_q`:** the address of the oldest unconsumed fetch. All PC arithmetic is mod 2^32, so 32'hFFFFFFFC+4 wraps to 0.
- **State REQ:**
  - Drive `imem_req`=!`StallF`&&!`PCSrcE`, with `imem_addr`=`pc_q`.
  - On `gnt`, go to WAIT.
  - `rvalid` is ignored in REQ.
- **State WAIT:** `rvalid` is ignored until it arrives.
  - On `rvalid` with `kill`=1: drop the data, clear `kill`, go to REQ.
  - On `rvalid` with `kill`=0 and !`StallD`: consume the instruction into IF/ID and set `pc_q`+=4.
    - In the same cycle, if !`StallF`&&!`PCSrcE`, drive `imem_req`=1 with `imem_addr`=`pc_q`+4. On `gnt`, stay in WAIT; otherwise go to REQ.
    - This overlap is a combinational `rvalid`→`imem_req` path and is accepted.
  - On `rvalid` with `kill`=0 and `StallD`: capture `rdata` into the hold buffer and go to HOLD.
- **State HOLD:**
  - Issue no request.
  - When !`StallD`: consume the buffer into IF/ID, set `pc_q`+=4, go to REQ.
- **IF/ID update each cycle:**
  - `FlushD`: load a bubble (`NOP_INSTR`, `PCD`=0, `PCPlus4D`=0, `ValidD`=0). This wins over `StallD` and over consume.
  - else `StallD`: hold.
  - else consume: load `rdata` or the buffer, `PCD`=`pc_q`, `PCPlus4D`=`pc_q`+4, `ValidD`=1.
  - else: load a bubble.
- **Redirect (`PCSrcE`):** highest priority after reset.
  - Set `pc_q`←`PCTargetE` and issue no request that cycle.
  - A response arriving that cycle is dropped.
  - An outstanding un-returned request sets `kill`=1 and stays in WAIT.
  - The hold buffer is discarded; HOLD goes to REQ.
  - A second redirect during a kill wait only updates `pc_q`.
- **`FetchBusy`:** 1 unless (state=HOLD) or (WAIT && `rvalid` && !`kill` && !`PCSrcE`).

## Timing
- **Zero-wait memory** (`gnt` combinational, `rvalid` the next cycle):
  - Reset release at cycle 0: request for `RESET_PC` at cycle 0.
  - `rvalid` at cycle 1; `ValidD`=1 at cycle 2.
  - Then 1 instruction per cycle.
- **Redirect at cycle N:** request for `PCTargetE` at N+1 (no kill pending); first target instruction in IF/ID at N+3.
- **Stall boundaries:**
  - A stall lasting exactly as long as the response is in flight loses no instruction.
  - Back-to-back `StallD` in HOLD holds indefinitely.
- **Reset mid-operation:** immediate async clear. A stale response after reset arrives in REQ and is ignored.

## Structure
- Shared package `riscv_pipe_pkg` holds:
  - `NOP_INSTR` and default `RESET_PC` constants.
  - The `fetch_state_t` enum (REQ, WAIT, HOLD).
  - The `XLEN`=32 constant.
- One sub-module, `ifid_reg`: the IF/ID register with stall/flush priority, reset to the bubble values.
- The FSM, `pc_q`, `kill` and the hold buffer live in `fetch_cycle`.

## Test plan
- **Reset release, zero-wait memory returning PC+0x100:** requests 0,4,8 on consecutive cycles; `ValidD`=1 from cycle 2 with `PCD`=0,4,8 and `PCPlus4D`=4,8,12.
- **`PCSrcE`=1 with `PCTargetE`=0x200 while a 3-cycle-latency request for 0x8 is outstanding:** 0x8 data dropped; next `imem_addr`=0x200; no IF/ID load carries `PCD`=0x8.
- **`StallD` asserted for 3 cycles as `rvalid` returns for 0x10:** state HOLD, IF/ID held, no request; on release `PCD`=0x10, then request 0x14.
- **`FlushD`&&`StallD` in the same cycle:** IF/ID becomes `NOP_INSTR`/`ValidD`=0; the pending instruction is still delivered once.
- **`pc_q`=0xFFFFFFFC:** `PCPlus4D`=0 and the next `imem_addr`=0.
- **`reset_n` pulsed low while WAIT:** outputs return to reset values; a late `rvalid` is ignored; the first request is `RESET_PC`.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: data width, bubble encoding, reset PC and the
// fetch-stage state type.
package riscv_pipe_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

  // Sequential successor address; wraps naturally at 2^32.
  function automatic logic [XLEN-1:0] seq_pc(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: flush beats stall beats load; an idle cycle
// drains to a bubble.
module ifid_reg
  import riscv_pipe_pkg::*;
(
  input  logic            clock,
  input  logic            reset_n,
  input  logic            flush_i,
  input  logic            stall_i,
  input  logic            load_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            valid_o
);

  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc4_q, pc4_d;
  logic            valid_q, valid_d;

  // Next IF/ID contents by flush / stall / load priority.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (flush_i) begin
      instr_d = NOP_INSTR;
      pc_d    = 32'h0000_0000;
      pc4_d   = 32'h0000_0000;
      valid_d = 1'b0;
    end else if (stall_i) begin
      instr_d = instr_q;
      pc_d    = pc_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
    end else if (load_i) begin
      instr_d = instr_i;
      pc_d    = pc_i;
      pc4_d   = seq_pc(pc_i);
      valid_d = 1'b1;
    end else begin
      instr_d = NOP_INSTR;
      pc_d    = 32'h0000_0000;
      pc4_d   = 32'h0000_0000;
      valid_d = 1'b0;
    end
  end

  // Register state, reset to the bubble.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      instr_q <= NOP_INSTR;
      pc_q    <= 32'h0000_0000;
      pc4_q   <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc4_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_cycle.sv
// Instruction-fetch stage: owns the fetch PC, runs a single-outstanding
// req/gnt/rvalid memory port and feeds the IF/ID register.
module fetch_cycle
  import riscv_pipe_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD,
  output logic            FetchBusy
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] hold_q, hold_d;
  logic            kill_q, kill_d;

  logic            req_s;
  logic [XLEN-1:0] addr_s;
  logic            consume_s;
  logic [XLEN-1:0] cons_data_s;
  logic            busy_s;
  logic            fresh_rsp_s;

  // A response that is neither killed nor overtaken by a redirect.
  assign fresh_rsp_s = imem_rvalid && !kill_q && !PCSrcE;

  // Memory request, consume strobe and busy flag for the current cycle.
  always_comb begin
    req_s       = 1'b0;
    addr_s      = pc_q;
    consume_s   = 1'b0;
    cons_data_s = imem_rdata;
    busy_s      = 1'b1;
    case (state_q)
      S_REQ: begin
        req_s = !StallF && !PCSrcE;
      end
      S_WAIT: begin
        // Overlapped request for the next word while consuming this one.
        addr_s = seq_pc(pc_q);
        if (fresh_rsp_s) begin
          busy_s    = 1'b0;
          consume_s = !StallD;
          req_s     = !StallD && !StallF;
        end else begin
          busy_s = 1'b1;
        end
      end
      S_HOLD: begin
        busy_s      = 1'b0;
        cons_data_s = hold_q;
        consume_s   = !StallD && !PCSrcE;
      end
      default: begin
        req_s = 1'b0;
      end
    endcase
  end

  // Next FSM state, fetch PC, kill flag and hold buffer.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kill_d  = kill_q;
    hold_d  = hold_q;
    if (PCSrcE) begin
      pc_d = PCTargetE;
      case (state_q)
        S_WAIT: begin
          if (imem_rvalid) begin
            state_d = S_REQ;
            kill_d  = 1'b0;
          end else begin
            kill_d = 1'b1;
          end
        end
        S_HOLD:  state_d = S_REQ;
        default: state_d = state_q;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (req_s && imem_gnt) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_REQ;
          end
        end
        S_WAIT: begin
          if (imem_rvalid && kill_q) begin
            state_d = S_REQ;
            kill_d  = 1'b0;
          end else if (consume_s) begin
            pc_d    = seq_pc(pc_q);
            state_d = (req_s && imem_gnt) ? S_WAIT : S_REQ;
          end else if (imem_rvalid) begin
            hold_d  = imem_rdata;
            state_d = S_HOLD;
          end else begin
            state_d = S_WAIT;
          end
        end
        S_HOLD: begin
          if (consume_s) begin
            pc_d    = seq_pc(pc_q);
            state_d = S_REQ;
          end else begin
            state_d = S_HOLD;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  // Fetch-side state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
      hold_q  <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      hold_q  <= hold_d;
    end
  end

  assign imem_req  = req_s && reset_n;
  assign imem_addr = addr_s;
  assign FetchBusy = busy_s;

  ifid_reg u_ifid (
    .clock      (clock),
    .reset_n    (reset_n),
    .flush_i    (FlushD),
    .stall_i    (StallD),
    .load_i     (consume_s),
    .instr_i    (cons_data_s),
    .pc_i       (pc_q),
    .instr_o    (InstrD),
    .pc_o       (PCD),
    .pc_plus4_o (PCPlus4D),
    .valid_o    (ValidD)
  );

endmodule

// File: tb/tb_fetch_cycle.sv
// Randomised bench for fetch_cycle: a program-order stream model feeds an
// expected-PC queue that a monitor pops on every IF/ID delivery.
module tb_fetch_cycle;
  import riscv_pipe_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n, StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD, FetchBusy;

  fetch_cycle dut (
    .clock(clock), .reset_n(reset_n), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .ValidD(ValidD), .FetchBusy(FetchBusy)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;
  int n_deliv = 0;

  logic        gnt_allow;
  int          lat_hi;
  assign imem_gnt = imem_req & gnt_allow;

  logic [31:0] exp_q[$];
  logic [31:0] next_pc;
  logic        exp_pend;
  logic [31:0] exp_addr;
  logic        last_hs;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a + 32'h0000_0100;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Program stream restarts at pc: earlier expectations are void.
  task automatic restart(input logic [31:0] pc);
    exp_q.delete();
    next_pc  = pc;
    exp_pend = 1'b1;
    exp_addr = pc;
    while (exp_q.size() < 8) begin
      exp_q.push_back(next_pc);
      next_pc = next_pc + 32'd4;
    end
  endtask

  task automatic step();
    @(negedge clock);
    last_hs = imem_req && imem_gnt;
    if (!reset_n) begin
      chk("req_in_reset", {31'd0, imem_req}, 32'd0);
    end else if (PCSrcE) begin
      chk("req_on_redirect", {31'd0, imem_req}, 32'd0);
    end else if (imem_req && exp_pend) begin
      chk("first_req_addr", imem_addr, exp_addr);
      exp_pend = 1'b0;
    end
    @(posedge clock);
    #2;
    while (exp_q.size() < 8) begin
      exp_q.push_back(next_pc);
      next_pc = next_pc + 32'd4;
    end
  endtask

  // Memory: one outstanding request, 1..lat_hi+1 cycles latency; frozen in reset.
  logic        mv, s_rst, s_hs, s_rv;
  logic [31:0] maddr, s_a;
  int          mcnt;
  initial begin
    mv = 1'b0; mcnt = 0; maddr = 32'd0;
    imem_rvalid = 1'b0; imem_rdata = 32'd0;
    forever begin
      @(negedge clock);
      s_rst = reset_n; s_hs = imem_req && imem_gnt; s_a = imem_addr; s_rv = imem_rvalid;
      @(posedge clock);
      #2;
      if (s_rst) begin
        if (s_rv) mv = 1'b0;
        else if (mv && mcnt > 0) mcnt--;
        if (s_hs) begin
          mv = 1'b1; maddr = s_a; mcnt = $urandom_range(lat_hi, 0);
        end
      end
      imem_rvalid = mv && (mcnt == 0);
      imem_rdata  = imem_rvalid ? memf(maddr) : $urandom;
    end
  end

  // Monitor: classify each IF/ID update and pop the scoreboard on deliveries.
  logic        m_stall, m_flush, m_busy, pv_v;
  logic [31:0] pv_i, pv_pc, pv_p4, e;
  initial begin
    pv_v = 1'b0; pv_i = NOP_INSTR; pv_pc = 32'd0; pv_p4 = 32'd0;
    forever begin
      @(negedge clock);
      m_stall = StallD; m_flush = FlushD; m_busy = FetchBusy;
      @(posedge clock);
      #1;
      if (!reset_n) begin
        chk("rst_valid", {31'd0, ValidD}, 32'd0);
        chk("rst_instr", InstrD, NOP_INSTR);
        chk("rst_pcd", PCD, 32'd0);
        chk("rst_pc4", PCPlus4D, 32'd0);
      end else if (m_flush) begin
        chk("flush_valid", {31'd0, ValidD}, 32'd0);
        chk("flush_instr", InstrD, NOP_INSTR);
        chk("flush_pcd", PCD, 32'd0);
        chk("flush_pc4", PCPlus4D, 32'd0);
      end else if (m_stall) begin
        chk("hold_valid", {31'd0, ValidD}, {31'd0, pv_v});
        chk("hold_instr", InstrD, pv_i);
        chk("hold_pcd", PCD, pv_pc);
      end else if (ValidD) begin
        chk("busy_at_deliver", {31'd0, m_busy}, 32'd0);
        if (exp_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL deliver_empty: got PCD %h expected no delivery", PCD);
        end else begin
          e = exp_q.pop_front();
          chk("deliver_pcd", PCD, e);
          chk("deliver_pc4", PCPlus4D, e + 32'd4);
          chk("deliver_instr", InstrD, memf(e));
          n_deliv++;
        end
      end else begin
        chk("idle_instr", InstrD, NOP_INSTR);
        chk("idle_pcd", PCD, 32'd0);
      end
      pv_v = ValidD; pv_i = InstrD; pv_pc = PCD; pv_p4 = PCPlus4D;
    end
  end

  int stall_left;
  int w;
  logic [31:0] tgt;
  initial begin
    reset_n = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
    PCTargetE = 32'd0; gnt_allow = 1'b1; lat_hi = 0; stall_left = 0; last_hs = 1'b0;
    restart(32'h0000_0000);
    repeat (3) step();
    reset_n = 1'b1;
    exp_pend = 1'b0;
    // Zero-wait memory: requests 0,4,8 back to back, first delivery at cycle 2.
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk("zw_req", {31'd0, imem_req}, 32'd1);
      chk("zw_addr", imem_addr, 32'(c * 4));
      @(posedge clock);
      #2;
      if (c == 0) chk("zw_valid_c1", {31'd0, ValidD}, 32'd0);
      if (c == 1) begin
        chk("zw_valid_c2", {31'd0, ValidD}, 32'd1);
        chk("zw_pcd_c2", PCD, 32'd0);
      end
    end
    repeat (4) step();

    lat_hi = 2;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 1500) begin
        // Reset while a request is outstanding; the stale reply lands in REQ.
        w = 0;
        while (!last_hs && w < 50) begin step(); w++; end
        chk("reset_window_hs", {31'd0, last_hs}, 32'd1);
        StallF = 1'b1; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; stall_left = 0;
        reset_n = 1'b0;
        restart(32'h0000_0000);
        repeat (2) step();
        reset_n = 1'b1;
        repeat (4) step();
      end
      gnt_allow = ($urandom_range(3, 0) != 0);
      StallF    = ($urandom_range(5, 0) == 0);
      if (stall_left > 0) begin
        StallD = 1'b1; stall_left--;
      end else if ($urandom_range(5, 0) == 0) begin
        StallD = 1'b1; stall_left = $urandom_range(3, 0);
      end else begin
        StallD = 1'b0;
      end
      PCSrcE = ($urandom_range(15, 0) == 0);
      if (PCSrcE) begin
        case ($urandom_range(3, 0))
          0:       tgt = 32'h0000_0200;
          1:       tgt = 32'hFFFF_FFF8;
          2:       tgt = 32'hFFFF_FFFC;
          default: tgt = $urandom & 32'hFFFF_FFFC;
        endcase
        PCTargetE = tgt;
        FlushD    = 1'b1;
        restart(tgt);
      end else begin
        PCTargetE = $urandom;
        FlushD    = StallD && ($urandom_range(3, 0) == 0);
      end
      step();
    end
    PCSrcE = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    repeat (8) step();
    chk("progress", {31'd0, n_deliv >= 200}, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
